// File: rtl/line_draw_if.sv
// -----------------------------------------------------------------------------
// line_draw_if
// Purpose : Bundles the endpoint/request inputs and the pixel-stream outputs
//           of the line_draw rasteriser into a single interface.
// Signals : x1, y1, x2, y2  - unsigned line endpoints (driven by the bus side)
//           DataValid        - request level; a rising edge starts a line
//           PixelReady       - downstream accepts the presented pixel
//           px, py           - current pixel coordinate
//           PixelValid       - px/py carry a valid pixel
//           Busy             - rasteriser is not idle
//           Done             - one-cycle pulse after the last pixel
//           Overrun          - sticky: a request arrived while busy
// Modports: master - the side that supplies endpoints and consumes pixels
//           slave  - the line_draw block itself
// -----------------------------------------------------------------------------
interface line_draw_if #(
  parameter int COORD_W = 9
);
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic [COORD_W-1:0] x2;
  logic [COORD_W-1:0] y2;
  logic               DataValid;
  logic               PixelReady;
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  logic               PixelValid;
  logic               Busy;
  logic               Done;
  logic               Overrun;

  modport master (
    output x1, y1, x2, y2, DataValid, PixelReady,
    input  px, py, PixelValid, Busy, Done, Overrun
  );

  modport slave (
    input  x1, y1, x2, y2, DataValid, PixelReady,
    output px, py, PixelValid, Busy, Done, Overrun
  );
endinterface

// File: rtl/line_draw.sv
// -----------------------------------------------------------------------------
// line_draw
// Purpose : Bresenham line rasteriser. A rising edge on DataValid captures the
//           endpoints; the block then streams every pixel of the line from
//           (x1,y1) to (x2,y2) with a valid/ready handshake and pulses Done
//           once the last pixel has been accepted.
// Ports   : HCLK    - clock, all state changes on the rising edge
//           HRESET  - synchronous active-high reset
//           bus     - line_draw_if.slave (endpoints, request, pixel stream,
//                     status flags)
// -----------------------------------------------------------------------------
module line_draw #(
  parameter int COORD_W = 9
) (
  input logic        HCLK,
  input logic        HRESET,
  line_draw_if.slave bus
);

  // dx/dy need one magnitude bit above the coordinate plus a sign bit;
  // err/e2 need one more so that 2*err and err+dx+dy cannot overflow.
  localparam int DW = COORD_W + 2;
  localparam int EW = COORD_W + 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic               r_dv;
  logic               r_arm;
  logic [COORD_W-1:0] r_x1;
  logic [COORD_W-1:0] r_y1;
  logic [COORD_W-1:0] r_x2;
  logic [COORD_W-1:0] r_y2;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic signed [DW-1:0] r_dx;
  logic signed [DW-1:0] r_dy;
  logic signed [EW-1:0] r_err;
  logic               r_sx_neg;
  logic               r_sy_neg;
  logic               r_pv;
  logic               r_busy;
  logic               r_done;
  logic               r_ovr;

  logic               w_req;
  logic               w_accept;
  logic               w_last;
  logic               w_sx_neg;
  logic               w_sy_neg;
  logic [COORD_W-1:0] w_dx_mag;
  logic [COORD_W-1:0] w_dy_mag;
  logic signed [DW-1:0] w_dx_s;
  logic signed [DW-1:0] w_dy_s;
  logic signed [EW-1:0] w_err_init;
  logic signed [EW-1:0] w_dx_e;
  logic signed [EW-1:0] w_dy_e;
  logic signed [EW-1:0] w_e2;
  logic               w_step_x;
  logic               w_step_y;
  logic signed [EW-1:0] w_err_nxt;

  // r_arm stays low after reset until DataValid has been seen low, so a level
  // left high across reset cannot masquerade as a fresh rising edge.
  assign w_req    = bus.DataValid & ~r_dv & r_arm;
  assign w_accept = r_pv & bus.PixelReady;
  assign w_last   = (r_x == r_x2) && (r_y == r_y2);

  // Setup-time geometry from the captured endpoints.
  assign w_sx_neg   = (r_x2 < r_x1);
  assign w_sy_neg   = (r_y2 < r_y1);
  assign w_dx_mag   = w_sx_neg ? (r_x1 - r_x2) : (r_x2 - r_x1);
  assign w_dy_mag   = w_sy_neg ? (r_y1 - r_y2) : (r_y2 - r_y1);
  assign w_dx_s     = $signed({2'b00, w_dx_mag});
  assign w_dy_s     = -$signed({2'b00, w_dy_mag});
  assign w_err_init = $signed({w_dx_s[DW-1], w_dx_s}) + $signed({w_dy_s[DW-1], w_dy_s});

  // Per-pixel step decision; both axes use the same pre-update e2.
  assign w_dx_e    = $signed({r_dx[DW-1], r_dx});
  assign w_dy_e    = $signed({r_dy[DW-1], r_dy});
  assign w_e2      = $signed({r_err[EW-2:0], 1'b0});
  assign w_step_x  = (w_e2 >= w_dy_e);
  assign w_step_y  = (w_e2 <= w_dx_e);
  assign w_err_nxt = r_err + (w_step_x ? w_dy_e : {EW{1'b0}})
                           + (w_step_y ? w_dx_e : {EW{1'b0}});

  // Next-state decode for the line sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: w_state_nxt = ST_DRAW;
      ST_DRAW: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAW;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, request edge detector and registered status outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_dv    <= 1'b0;
      r_arm   <= 1'b0;
      r_pv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dv    <= bus.DataValid;
      r_arm   <= r_arm | ~bus.DataValid;
      r_pv    <= (w_state_nxt == ST_DRAW);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
      // Includes the DONE cycle, whose successor is IDLE but is still busy.
      if (w_req && (r_state != ST_IDLE)) begin
        r_ovr <= 1'b1;
      end
    end
  end

  // Endpoint capture and Bresenham datapath.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_x1     <= {COORD_W{1'b0}};
      r_y1     <= {COORD_W{1'b0}};
      r_x2     <= {COORD_W{1'b0}};
      r_y2     <= {COORD_W{1'b0}};
      r_x      <= {COORD_W{1'b0}};
      r_y      <= {COORD_W{1'b0}};
      r_dx     <= {DW{1'b0}};
      r_dy     <= {DW{1'b0}};
      r_err    <= {EW{1'b0}};
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_x1 <= bus.x1;
            r_y1 <= bus.y1;
            r_x2 <= bus.x2;
            r_y2 <= bus.y2;
          end
        end
        ST_SETUP: begin
          r_dx     <= w_dx_s;
          r_dy     <= w_dy_s;
          r_err    <= w_err_init;
          r_sx_neg <= w_sx_neg;
          r_sy_neg <= w_sy_neg;
          r_x      <= r_x1;
          r_y      <= r_y1;
        end
        ST_DRAW: begin
          // The walk stops on the endpoint, so x/y never step past it.
          if (w_accept && !w_last) begin
            r_err <= w_err_nxt;
            if (w_step_x) begin
              r_x <= r_sx_neg ? (r_x - 1'b1) : (r_x + 1'b1);
            end
            if (w_step_y) begin
              r_y <= r_sy_neg ? (r_y - 1'b1) : (r_y + 1'b1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.px         = r_x;
  assign bus.py         = r_y;
  assign bus.PixelValid = r_pv;
  assign bus.Busy       = r_busy;
  assign bus.Done       = r_done;
  assign bus.Overrun    = r_ovr;

endmodule

// File: tb/tb_line_draw.sv
// -----------------------------------------------------------------------------
// tb_line_draw
// Scoreboard bench for line_draw: stimulus pushes expected pixels into a queue,
// a negedge monitor pops and compares every accepted pixel, checks hold
// behaviour under backpressure and validates each Done pulse.
// -----------------------------------------------------------------------------
module tb_line_draw;

  localparam int CW = 9;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;

  line_draw_if #(.COORD_W(CW)) bus ();

  line_draw #(.COORD_W(CW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int lines_pending = 0;
  int rdy_mode = 0;
  int exp_x[$];
  int exp_y[$];

  logic        prev_hold = 1'b0;
  logic [CW-1:0] prev_px = '0;
  logic [CW-1:0] prev_py = '0;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic exp_pt(input int x, input int y);
    exp_x.push_back(x);
    exp_y.push_back(y);
  endtask

  // Reference rasteriser: textbook integer Bresenham over plain ints.
  task automatic model_push(input int x1, input int y1, input int x2, input int y2);
    int dx, dy, sx, sy, err, e2, x, y, guard;
    dx  = (x2 >= x1) ? x2 - x1 : x1 - x2;
    dy  = -((y2 >= y1) ? y2 - y1 : y1 - y2);
    sx  = (x2 >= x1) ? 1 : -1;
    sy  = (y2 >= y1) ? 1 : -1;
    err = dx + dy;
    x = x1;
    y = y1;
    for (guard = 0; guard < 4096; guard++) begin
      exp_pt(x, y);
      if (x == x2 && y == y2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Raise DataValid for one cycle with the given endpoints; returns 1 time
  // unit after the edge that samples the request.
  task automatic req_line(input int x1, input int y1, input int x2, input int y2);
    @(posedge HCLK); #1;
    bus.x1 = x1[CW-1:0];
    bus.y1 = y1[CW-1:0];
    bus.x2 = x2[CW-1:0];
    bus.y2 = y2[CW-1:0];
    lines_pending++;
    bus.DataValid = 1'b1;
    @(posedge HCLK); #1;
    bus.DataValid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge HCLK); #1;
      if (lines_pending == 0 && !bus.Busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d left=%0d", bus.Busy, lines_pending, exp_x.size());
      exp_x.delete();
      exp_y.delete();
      lines_pending = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge HCLK); #1;
    HRESET = 1'b1;
    bus.DataValid = 1'b0;
    exp_x.delete();
    exp_y.delete();
    lines_pending = 0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
  endtask

  // PixelReady generator: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    bus.PixelReady = 1'b1;
    forever begin
      @(posedge HCLK); #1;
      case (rdy_mode)
        1:       bus.PixelReady = ~bus.PixelReady;
        2:       bus.PixelReady = ($urandom_range(0, 3) != 0);
        default: bus.PixelReady = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pops, hold-stability and Done validation.
  always @(negedge HCLK) begin
    if (HRESET) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_pv", bus.PixelValid, 1);
        chk("hold_px", bus.px, prev_px);
        chk("hold_py", bus.py, prev_py);
      end
      if (bus.PixelValid && bus.PixelReady) begin
        n_acc++;
        if (exp_x.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", bus.px, bus.py);
        end else begin
          chk("pixel_x", bus.px, exp_x.pop_front());
          chk("pixel_y", bus.py, exp_y.pop_front());
        end
      end
      if (bus.Done) begin
        chk("done_pv_low", bus.PixelValid, 0);
        chk("done_queue_empty", exp_x.size(), 0);
        chk("done_expected", (lines_pending > 0) ? 1 : 0, 1);
        if (lines_pending > 0) lines_pending--;
      end
      prev_hold = bus.PixelValid && !bus.PixelReady;
      prev_px   = bus.px;
      prev_py   = bus.py;
    end
  end

  initial begin
    int base, x1, y1, x2, y2, lim;
    bit hit;
    bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
    bus.DataValid = 1'b0;

    // Reset state.
    do_reset();
    @(negedge HCLK); #1;
    chk("rst_pv", bus.PixelValid, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_ovr", bus.Overrun, 0);
    chk("rst_px", bus.px, 0);
    chk("rst_py", bus.py, 0);

    // Horizontal line: latency and back-to-back pixels, Done right after.
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) exp_pt(i, 0);
    req_line(0, 0, 3, 0);
    @(negedge HCLK);
    chk("lat_setup_pv", bus.PixelValid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("h_pv", bus.PixelValid, 1);
      chk("h_px", bus.px, i);
      chk("h_py", bus.py, 0);
    end
    @(negedge HCLK);
    chk("h_done", bus.Done, 1);
    wait_idle(20);

    // Single-point line; a request during DONE is an overrun and is ignored.
    exp_pt(5, 5);
    req_line(5, 5, 5, 5);
    @(negedge HCLK);
    chk("pt_setup_pv", bus.PixelValid, 0);
    @(negedge HCLK);
    chk("pt_pv", bus.PixelValid, 1);
    chk("pt_px", bus.px, 5);
    chk("pt_py", bus.py, 5);
    @(posedge HCLK); #1;
    bus.x1 = 9'd1; bus.y1 = 9'd2; bus.x2 = 9'd30; bus.y2 = 9'd40;
    bus.DataValid = 1'b1;
    @(negedge HCLK);
    chk("pt_done", bus.Done, 1);
    @(posedge HCLK); #1;
    bus.DataValid = 1'b0;
    @(negedge HCLK);
    chk("done_edge_ovr", bus.Overrun, 1);
    chk("done_edge_busy", bus.Busy, 0);
    repeat (10) @(negedge HCLK);
    chk("done_edge_no_line", bus.Busy, 0);

    // Reverse diagonal and steep line.
    for (int i = 3; i >= 0; i--) exp_pt(i, i);
    req_line(3, 3, 0, 0);
    wait_idle(50);
    exp_pt(0, 0); exp_pt(0, 1); exp_pt(1, 2); exp_pt(1, 3);
    req_line(0, 0, 1, 3);
    wait_idle(50);

    // Full-range diagonal with ready toggling every cycle.
    rdy_mode = 1;
    base = n_acc;
    for (int i = 0; i < 512; i++) exp_pt(i, i);
    req_line(0, 0, 511, 511);
    wait_idle(3000);
    chk("diag_count", n_acc - base, 512);

    // Randomised lines against the reference model.
    for (int t = 0; t < 24; t++) begin
      rdy_mode = $urandom_range(0, 2);
      lim = (t % 2 == 0) ? 15 : 511;
      x1 = $urandom_range(0, lim); y1 = $urandom_range(0, lim);
      x2 = $urandom_range(0, lim); y2 = $urandom_range(0, lim);
      base = n_acc;
      model_push(x1, y1, x2, y2);
      req_line(x1, y1, x2, y2);
      wait_idle(4000);
      chk("rand_count", n_acc - base,
          (((x2 > x1) ? x2 - x1 : x1 - x2) > ((y2 > y1) ? y2 - y1 : y1 - y2) ?
           ((x2 > x1) ? x2 - x1 : x1 - x2) : ((y2 > y1) ? y2 - y1 : y1 - y2)) + 1);
    end

    // Overrun mid-line: second request and endpoint changes have no effect.
    do_reset();
    @(negedge HCLK); #1;
    chk("ovr_cleared", bus.Overrun, 0);
    rdy_mode = 2;
    model_push(0, 0, 40, 7);
    req_line(0, 0, 40, 7);
    repeat (8) @(negedge HCLK);
    #1;
    bus.x1 = 9'd100; bus.y1 = 9'd100; bus.x2 = 9'd200; bus.y2 = 9'd200;
    bus.DataValid = 1'b1;
    @(posedge HCLK); #1;
    bus.DataValid = 1'b0;
    @(negedge HCLK);
    chk("ovr_set", bus.Overrun, 1);
    chk("ovr_busy", bus.Busy, 1);
    wait_idle(400);
    repeat (10) @(negedge HCLK);
    chk("ovr_no_second", bus.Busy, 0);
    chk("ovr_sticky", bus.Overrun, 1);

    // Reset after three pixels; DataValid held high across reset.
    rdy_mode = 0;
    base = n_acc;
    model_push(0, 0, 9, 0);
    req_line(0, 0, 9, 0);
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge HCLK); #1;
      if (n_acc - base >= 3) begin hit = 1'b1; break; end
    end
    chk("mid_reach3", hit, 1);
    HRESET = 1'b1;
    bus.x1 = 9'd2; bus.y1 = 9'd2; bus.x2 = 9'd4; bus.y2 = 9'd4;
    bus.DataValid = 1'b1;
    @(negedge HCLK); #1;
    chk("mid_pv", bus.PixelValid, 0);
    chk("mid_busy", bus.Busy, 0);
    chk("mid_ovr", bus.Overrun, 0);
    chk("mid_done", bus.Done, 0);
    exp_x.delete();
    exp_y.delete();
    lines_pending = 0;
    HRESET = 1'b0;
    repeat (6) @(negedge HCLK);
    chk("held_dv_no_line", bus.Busy, 0);
    #1 bus.DataValid = 1'b0;
    model_push(2, 2, 4, 4);
    req_line(2, 2, 4, 4);
    wait_idle(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
